// File: rtl/ring_rr_scheduler_pkg.sv
// Shared types, default parameters and helpers for the ring round-robin scheduler.
package ring_rr_scheduler_pkg;

    localparam int unsigned DEF_N          = 4;
    localparam int unsigned DEF_GAP_CYCLES = 1;
    localparam int unsigned DEF_MAX_HOLD   = 16;

    // Widest requester count the rotate helper supports.
    localparam int unsigned MAX_N   = 32;
    localparam int unsigned MAX_NP1 = MAX_N + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    // Rotate a one-hot vector of width n left by one; bit n-1 wraps to bit 0.
    function automatic logic [MAX_N-1:0] rotl1(input logic [MAX_N-1:0] v, input int unsigned n);
        logic [MAX_NP1-1:0] keep;
        logic [MAX_N-1:0]   lo;
        logic [MAX_N-1:0]   top;
        logic [MAX_N-1:0]   r;
        keep = MAX_NP1'(1) << n;
        keep = keep - MAX_NP1'(1);
        lo   = keep[MAX_N-1:0];
        top  = lo ^ (lo >> 1);
        r    = (v << 1) & lo;
        r[0] = |(v & top);
        return r;
    endfunction

endpackage

// File: rtl/ring_rr_scheduler_if.sv
// Request/grant bundle between requesters and the ring round-robin scheduler.
interface ring_rr_scheduler_if
    import ring_rr_scheduler_pkg::*;
#(
    parameter int unsigned N = DEF_N
);
    logic [N-1:0] Req_in;
    logic [N-1:0] Grant_out;
    logic [N-1:0] Ptr_out;
    logic         Busy_out;
    logic         Timeout_out;

    modport master (output Req_in, input Grant_out, Ptr_out, Busy_out, Timeout_out);
    modport slave  (input Req_in, output Grant_out, Ptr_out, Busy_out, Timeout_out);
endinterface

// File: rtl/ring_rr_pick.sv
// Combinational round-robin winner: first request at or above the pointer, wrapping.
module ring_rr_pick
    import ring_rr_scheduler_pkg::*;
#(
    parameter int unsigned N = DEF_N
) (
    input  logic [N-1:0] req,
    input  logic [N-1:0] ptr,
    output logic [N-1:0] winner_c
);
    localparam int unsigned W2 = 2 * N;

    logic [W2-1:0] masked;
    logic [W2-1:0] first;

    // Low copy keeps only bits at/above the pointer; high copy supplies the wrap.
    assign masked   = {req, req & ~(ptr - N'(1))};
    assign first    = masked & (~masked + W2'(1));
    assign winner_c = first[N-1:0] | first[W2-1:N];
endmodule

// File: rtl/ring_rr_scheduler.sv
// Ring round-robin scheduler: one grant at a time, held until release, then a turnaround gap.
// Optional forced release after MAX_HOLD cycles when RING_RR_SCHEDULER_TIMEOUT_EN is defined.
module ring_rr_scheduler
    import ring_rr_scheduler_pkg::*;
#(
    parameter int unsigned N          = DEF_N,
    parameter int unsigned GAP_CYCLES = DEF_GAP_CYCLES,
    parameter int unsigned MAX_HOLD   = DEF_MAX_HOLD
) (
    input  logic               Clock,
    input  logic               Reset,
    ring_rr_scheduler_if.slave bus
);
    localparam int unsigned GAP_W  = $clog2(GAP_CYCLES + 1);
    localparam int unsigned HOLD_W = $clog2(MAX_HOLD);

    if (N < 2 || N > MAX_N || GAP_CYCLES < 1 || MAX_HOLD < 2) begin : g_bad_cfg
        $error("ring_rr_scheduler: unsupported parameter combination");
    end

    state_t             state_q, state_d;
    logic [N-1:0]       grant_q, grant_d;
    logic [N-1:0]       ptr_q, ptr_d;
    logic               busy_q, busy_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic [N-1:0]       winner_c;
    logic               rel_c;
`ifdef RING_RR_SCHEDULER_TIMEOUT_EN
    logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
    logic               timeout_q, timeout_d;
`endif

    ring_rr_pick #(.N(N)) u_pick (
        .req      (bus.Req_in),
        .ptr      (ptr_q),
        .winner_c (winner_c)
    );

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            ptr_q      <= N'(1);
            busy_q     <= 1'b0;
            gap_cnt_q  <= '0;
`ifdef RING_RR_SCHEDULER_TIMEOUT_EN
            hold_cnt_q <= '0;
            timeout_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            ptr_q      <= ptr_d;
            busy_q     <= busy_d;
            gap_cnt_q  <= gap_cnt_d;
`ifdef RING_RR_SCHEDULER_TIMEOUT_EN
            hold_cnt_q <= hold_cnt_d;
            timeout_q  <= timeout_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        ptr_d      = ptr_q;
        busy_d     = busy_q;
        gap_cnt_d  = gap_cnt_q;
        rel_c      = 1'b0;
`ifdef RING_RR_SCHEDULER_TIMEOUT_EN
        hold_cnt_d = hold_cnt_q;
        timeout_d  = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (winner_c != '0) begin
                    grant_d    = winner_c;
                    busy_d     = 1'b1;
                    state_d    = GRANT;
`ifdef RING_RR_SCHEDULER_TIMEOUT_EN
                    hold_cnt_d = '0;
`endif
                end
            end
            GRANT: begin
                // Only the owner's request matters; everyone else waits.
                if ((bus.Req_in & grant_q) == '0) begin
                    rel_c = 1'b1;
`ifdef RING_RR_SCHEDULER_TIMEOUT_EN
                end else if (hold_cnt_q == HOLD_W'(MAX_HOLD - 1)) begin
                    rel_c     = 1'b1;
                    timeout_d = 1'b1;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
`endif
                end
                if (rel_c) begin
                    grant_d   = '0;
                    busy_d    = 1'b0;
                    ptr_d     = N'(rotl1(MAX_N'(grant_q), N));
                    gap_cnt_d = '0;
                    state_d   = GAP;
                end
            end
            GAP: begin
                if (gap_cnt_q == GAP_W'(GAP_CYCLES - 1)) begin
                    state_d = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.Grant_out = grant_q;
    assign bus.Ptr_out   = ptr_q;
    assign bus.Busy_out  = busy_q;
`ifdef RING_RR_SCHEDULER_TIMEOUT_EN
    assign bus.Timeout_out = timeout_q;
`else
    assign bus.Timeout_out = 1'b0;
`endif
endmodule
